// File: rtl/id_ex_operand_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_pkg
//   Shared constants for the ID/EX operand stage: ALU control codes, ALUOp
//   encodings, R-type funct codes, the registered control bundle type and
//   the ALUOp/funct -> ALU control decode function.
// ----------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

  // 3-bit ALU control codes understood by the downstream ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp encodings produced by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct field codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  // Control signals that simply travel through the stage
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  // ALUOp/funct -> ALU control; unknown funct falls back to ADD
  function automatic logic [2:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [5:0] funct);
    logic [2:0] code;
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_OR:  code = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: code = ALU_ADD;
          FUNCT_SUB: code = ALU_SUB;
          FUNCT_AND: code = ALU_AND;
          FUNCT_OR:  code = ALU_OR;
          FUNCT_SLT: code = ALU_SLT;
          FUNCT_MUL: code = ALU_MUL;
          default:   code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_fwd_mux
//   Operand forwarding mux for one source register.
//   Ports:
//     i_addr        registered source register address
//     i_data        registered register-file data
//     i_exmem_*     EX/MEM write enable, destination, ALU result
//     i_memwb_*     MEM/WB write enable, destination, write-back data
//     o_data        selected operand (EX/MEM > MEM/WB > register file)
// ----------------------------------------------------------------------------
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_exmem_we,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_data,
  input  logic              i_memwb_we,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // Hit detection and priority select; register 0 is hard-wired and never forwarded
  always_comb begin
    w_exmem_hit = i_exmem_we && (i_exmem_rd != {REG_AW{1'b0}}) && (i_exmem_rd == i_addr);
    w_memwb_hit = i_memwb_we && (i_memwb_rd != {REG_AW{1'b0}}) && (i_memwb_rd == i_addr);
    if (w_exmem_hit) begin
      o_data = i_exmem_data;
    end else if (w_memwb_hit) begin
      o_data = i_memwb_data;
    end else begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register plus operand forwarding in front of the ALU.
//   Inputs : clk_i, rst_i (sync, active high), stall_i, flush_i, valid_i,
//            ID operands (rs/rt data, imm, rs/rt/rd addresses), decode
//            controls (reg_dst, alu_src, alu_op, funct, mem/reg controls),
//            EX/MEM and MEM/WB forwarding sources.
//   Outputs: ALU operands and control, store data, destination register,
//            registered valid/control, combinational load-use hazard flag.
// ----------------------------------------------------------------------------
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              reg_dst_i,
  input  logic              alu_src_i,
  input  logic [1:0]        alu_op_i,
  input  logic [5:0]        funct_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  output logic [2:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] dst_addr_o,
  output logic              valid_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic              load_use_o
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_dst;
  logic              r_alu_src;
  logic [2:0]        r_alu_ctrl;
  ctrl_t             r_ctrl;

  logic [REG_AW-1:0] w_dst;
  logic [2:0]        w_alu_ctrl;
  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Destination select, ALU control decode and control bundling ahead of the register
  always_comb begin
    if (reg_dst_i) begin
      w_dst = rd_addr_i;
    end else begin
      w_dst = rt_addr_i;
    end
    w_alu_ctrl        = alu_decode(alu_op_i, funct_i);
    w_ctrl.mem_read   = mem_read_i;
    w_ctrl.mem_write  = mem_write_i;
    w_ctrl.reg_write  = reg_write_i;
    w_ctrl.mem_to_reg = mem_to_reg_i;
  end

  // Stage register: reset and flush both insert a bubble; stall holds everything
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid    <= 1'b0;
      r_rs_data  <= {DATA_W{1'b0}};
      r_rt_data  <= {DATA_W{1'b0}};
      r_imm      <= {DATA_W{1'b0}};
      r_rs_addr  <= {REG_AW{1'b0}};
      r_rt_addr  <= {REG_AW{1'b0}};
      r_dst      <= {REG_AW{1'b0}};
      r_alu_src  <= 1'b0;
      r_alu_ctrl <= 3'b000;
      r_ctrl     <= '{1'b0, 1'b0, 1'b0, 1'b0};
    end else if (!stall_i) begin
      r_valid    <= valid_i;
      r_rs_data  <= rs_data_i;
      r_rt_data  <= rt_data_i;
      r_imm      <= imm_i;
      r_rs_addr  <= rs_addr_i;
      r_rt_addr  <= rt_addr_i;
      r_dst      <= w_dst;
      r_alu_src  <= alu_src_i;
      r_alu_ctrl <= w_alu_ctrl;
      r_ctrl     <= w_ctrl;
    end
  end

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_addr       (r_rs_addr),
    .i_data       (r_rs_data),
    .i_exmem_we   (exmem_reg_write_i),
    .i_exmem_rd   (exmem_rd_i),
    .i_exmem_data (exmem_data_i),
    .i_memwb_we   (memwb_reg_write_i),
    .i_memwb_rd   (memwb_rd_i),
    .i_memwb_data (memwb_data_i),
    .o_data       (w_fwd_rs)
  );

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_addr       (r_rt_addr),
    .i_data       (r_rt_data),
    .i_exmem_we   (exmem_reg_write_i),
    .i_exmem_rd   (exmem_rd_i),
    .i_exmem_data (exmem_data_i),
    .i_memwb_we   (memwb_reg_write_i),
    .i_memwb_rd   (memwb_rd_i),
    .i_memwb_data (memwb_data_i),
    .o_data       (w_fwd_rt)
  );

  // Operand routing; store data always takes the forwarded rt even for immediates
  always_comb begin
    alu_data1_o  = w_fwd_rs;
    store_data_o = w_fwd_rt;
    if (r_alu_src) begin
      alu_data2_o = r_imm;
    end else begin
      alu_data2_o = w_fwd_rt;
    end
  end

  // Load-use compares the held load's destination against the instruction now in ID
  always_comb begin
    load_use_o = r_valid && r_ctrl.mem_read && (r_dst != {REG_AW{1'b0}}) &&
                 ((r_dst == rs_addr_i) || (r_dst == rt_addr_i));
  end

  assign alu_ctrl_o   = r_alu_ctrl;
  assign dst_addr_o   = r_dst;
  assign valid_o      = r_valid;
  assign mem_read_o   = r_ctrl.mem_read;
  assign mem_write_o  = r_ctrl.mem_write;
  assign reg_write_o  = r_ctrl.reg_write;
  assign mem_to_reg_o = r_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_i, stall_i, flush_i, valid_i;
  logic [DW-1:0] rs_data_i, rt_data_i, imm_i;
  logic [AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
  logic          reg_dst_i, alu_src_i;
  logic [1:0]    alu_op_i;
  logic [5:0]    funct_i;
  logic          mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
  logic          exmem_reg_write_i;
  logic [AW-1:0] exmem_rd_i;
  logic [DW-1:0] exmem_data_i;
  logic          memwb_reg_write_i;
  logic [AW-1:0] memwb_rd_i;
  logic [DW-1:0] memwb_data_i;
  logic [DW-1:0] alu_data1_o, alu_data2_o, store_data_o;
  logic [2:0]    alu_ctrl_o;
  logic [AW-1:0] dst_addr_o;
  logic          valid_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, load_use_o;

  int checks = 0;
  int errors = 0;

  id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .reg_dst_i(reg_dst_i), .alu_src_i(alu_src_i), .alu_op_i(alu_op_i), .funct_i(funct_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .mem_to_reg_i(mem_to_reg_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .dst_addr_o(dst_addr_o), .valid_o(valid_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .load_use_o(load_use_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: what the stage holds after each edge
  logic          m_ok = 1'b0;
  logic          m_valid, m_src, m_mr, m_mw, m_rw, m_m2r;
  logic [DW-1:0] m_rsd, m_rtd, m_imm;
  logic [AW-1:0] m_rs, m_rt, m_dst;
  logic [2:0]    m_ctrl;

  function automatic logic [2:0] exp_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 3'b010;
    if (op == 2'd1) return 3'b110;
    if (op == 2'd3) return 3'b001;
    if (f == 6'b100000) return 3'b010;
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    if (f == 6'b101010) return 3'b111;
    if (f == 6'b011000) return 3'b011;
    return 3'b010;
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (exmem_reg_write_i && exmem_rd_i != 0 && exmem_rd_i == a) return exmem_data_i;
    if (memwb_reg_write_i && memwb_rd_i != 0 && memwb_rd_i == a) return memwb_data_i;
    return rf;
  endfunction

  always @(posedge clk) begin
    if (rst_i || flush_i) begin
      if (rst_i) m_ok <= 1'b1;
      m_valid <= 0; m_src <= 0; m_mr <= 0; m_mw <= 0; m_rw <= 0; m_m2r <= 0;
      m_rsd <= 0; m_rtd <= 0; m_imm <= 0; m_rs <= 0; m_rt <= 0; m_dst <= 0; m_ctrl <= 0;
    end else if (!stall_i) begin
      m_valid <= valid_i; m_src <= alu_src_i; m_mr <= mem_read_i; m_mw <= mem_write_i;
      m_rw <= reg_write_i; m_m2r <= mem_to_reg_i;
      m_rsd <= rs_data_i; m_rtd <= rt_data_i; m_imm <= imm_i;
      m_rs <= rs_addr_i; m_rt <= rt_addr_i;
      m_dst <= reg_dst_i ? rd_addr_i : rt_addr_i;
      m_ctrl <= exp_ctrl(alu_op_i, funct_i);
    end
  end

  // ---------------- compare process, mid-cycle
  always @(negedge clk) begin
    if (m_ok) begin
      chk("alu_data1", alu_data1_o, fwd(m_rs, m_rsd));
      chk("alu_data2", alu_data2_o, m_src ? m_imm : fwd(m_rt, m_rtd));
      chk("store_data", store_data_o, fwd(m_rt, m_rtd));
      chk("alu_ctrl", 32'(alu_ctrl_o), 32'(m_ctrl));
      chk("dst_addr", 32'(dst_addr_o), 32'(m_dst));
      chk("valid", 32'(valid_o), 32'(m_valid));
      chk("ctrl", 32'({mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o}),
          32'({m_mr, m_mw, m_rw, m_m2r}));
      chk("load_use", 32'(load_use_o),
          32'(m_valid && m_mr && m_dst != 0 && (m_dst == rs_addr_i || m_dst == rt_addr_i)));
    end
  end

  // ---------------- stimulus helpers
  task automatic rand_inputs();
    rst_i = 1'b0;
    stall_i = ($urandom_range(0, 7) == 0);
    flush_i = ($urandom_range(0, 9) == 0);
    valid_i = 1'($urandom);
    rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
    rs_addr_i = 5'($urandom_range(0, 7)); rt_addr_i = 5'($urandom_range(0, 7));
    rd_addr_i = 5'($urandom_range(0, 7));
    reg_dst_i = 1'($urandom); alu_src_i = 1'($urandom);
    alu_op_i = 2'($urandom);
    case ($urandom_range(0, 6))
      0: funct_i = 6'b100000; 1: funct_i = 6'b100010; 2: funct_i = 6'b100100;
      3: funct_i = 6'b100101; 4: funct_i = 6'b101010; 5: funct_i = 6'b011000;
      default: funct_i = 6'($urandom);
    endcase
    mem_read_i = 1'($urandom); mem_write_i = 1'($urandom);
    reg_write_i = 1'($urandom); mem_to_reg_i = 1'($urandom);
    exmem_reg_write_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(0, 7)); exmem_data_i = $urandom;
    memwb_reg_write_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(0, 7)); memwb_data_i = $urandom;
  endtask

  task automatic quiet();
    rand_inputs();
    stall_i = 0; flush_i = 0; valid_i = 1;
    reg_dst_i = 0; alu_src_i = 0; alu_op_i = 2'b00; funct_i = 6'd0;
    mem_read_i = 0; mem_write_i = 0; reg_write_i = 0; mem_to_reg_i = 0;
    exmem_reg_write_i = 0; memwb_reg_write_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] snap;

  initial begin
    // 1. reset with random inputs for 2 cycles
    rand_inputs(); rst_i = 1'b1; step();
    rand_inputs(); rst_i = 1'b1; step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ctrl", 32'({mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o}), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    chk("rst_dst", 32'(dst_addr_o), 32'd0);
    chk("rst_data1", alu_data1_o, 32'd0);
    chk("rst_data2", alu_data2_o, 32'd0);
    chk("rst_store", store_data_o, 32'd0);
    chk("rst_load_use", 32'(load_use_o), 32'd0);

    // 2. decode
    quiet(); alu_op_i = 2'b10; funct_i = 6'b101010; step();
    chk("dec_slt", 32'(alu_ctrl_o), 32'd7);
    funct_i = 6'b011000; step();
    chk("dec_mul", 32'(alu_ctrl_o), 32'd3);
    alu_op_i = 2'b01; step();
    chk("dec_sub", 32'(alu_ctrl_o), 32'd6);

    // 3. forwarding priority
    quiet(); rs_addr_i = 5'd5; rs_data_i = 32'h0000_1234;
    exmem_reg_write_i = 1; exmem_rd_i = 5'd5; exmem_data_i = 32'hAAAA_0000;
    memwb_reg_write_i = 1; memwb_rd_i = 5'd5; memwb_data_i = 32'h0000_5555;
    step();
    chk("fwd_exmem", alu_data1_o, 32'hAAAA_0000);
    exmem_reg_write_i = 0; #1;
    chk("fwd_memwb", alu_data1_o, 32'h0000_5555);

    // 4. register 0 never forwarded
    quiet(); rs_addr_i = 5'd0; rs_data_i = 32'd0;
    exmem_reg_write_i = 1; exmem_rd_i = 5'd0; exmem_data_i = 32'hFFFF_FFFF;
    memwb_reg_write_i = 1; memwb_rd_i = 5'd0; memwb_data_i = 32'hFFFF_FFFF;
    step();
    chk("fwd_r0", alu_data1_o, 32'd0);

    // 5. stall holds, flush beats stall
    quiet(); reg_write_i = 1; reg_dst_i = 1; rd_addr_i = 5'd9; alu_op_i = 2'b01; step();
    snap = {alu_data1_o, alu_data2_o, store_data_o, 3'(alu_ctrl_o), dst_addr_o, valid_o,
            mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, 19'd0};
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); stall_i = 1; flush_i = 0; exmem_reg_write_i = 0; memwb_reg_write_i = 0;
      step();
      chk("stall_hold_hi", snap[127:96], alu_data1_o);
      chk("stall_hold_lo", snap[95:19],
          {alu_data2_o, store_data_o, 3'(alu_ctrl_o), dst_addr_o, valid_o,
           mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o});
    end
    flush_i = 1; stall_i = 1; step();
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_reg_write", 32'(reg_write_o), 32'd0);

    // 6. load-use
    quiet(); mem_read_i = 1; reg_dst_i = 0; rt_addr_i = 5'd8; rd_addr_i = 5'd3; step();
    rs_addr_i = 5'd3; rt_addr_i = 5'd8; #1;
    chk("load_use_hit", 32'(load_use_o), 32'd1);
    quiet(); mem_read_i = 1; reg_dst_i = 0; rt_addr_i = 5'd0; step();
    rs_addr_i = 5'd3; rt_addr_i = 5'd0; #1;
    chk("load_use_r0", 32'(load_use_o), 32'd0);

    // random phase against the model
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      rst_i = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
